// File: rtl/trax_pkg.sv
//------------------------------------------------------------------------------
// trax_pkg : shared widths and stack operation encoding for the trax engine
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package trax_pkg;

   localparam int TRAX_WORD_W  = 22;
   localparam int STACK_ADDR_W = 6;

   typedef enum logic [2:0] {
      NOP      = 3'd0,
      PUSH     = 3'd1,
      POP      = 3'd2,
      REPLACE  = 3'd3,
      ROLLBACK = 3'd4
   } stack_op_e;

endpackage

`default_nettype wire

// File: rtl/lifo_mem.sv
//------------------------------------------------------------------------------
// lifo_mem : 2^ADDR_W x WIDTH RAM, one write port, async top read, sync peek read
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lifo_mem #(
   parameter int WIDTH  = 22,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]  rdata_a,
   input  logic              re_b,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_b
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   // Sync read returns the pre-edge contents when it collides with a write.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re_b)
         rdata_b <= mem[raddr_b];
   end

   assign rdata_a = mem[raddr_a];

endmodule

`default_nettype wire

// File: rtl/lifo_stack_ctrl.sv
//------------------------------------------------------------------------------
// lifo_stack_ctrl : parametrised LIFO with replace, peek, sticky errors, mark/rollback
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lifo_stack_ctrl
   import trax_pkg::*;
#(
   parameter int WIDTH    = TRAX_WORD_W,
   parameter int ADDR_W   = STACK_ADDR_W,
   parameter int AF_LEVEL = 56
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  d_in,
   input  logic              mark,
   input  logic              rollback,
   input  logic              err_clr,
   input  logic [ADDR_W-1:0] peek_idx,
   input  logic              peek_req,
   output logic [WIDTH-1:0]  top_data,
   output logic [WIDTH-1:0]  peek_data,
   output logic              peek_valid,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              of,
   output logic              uf
);

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   logic [ADDR_W:0]   mark_ptr;
   logic [ADDR_W:0]   nxt_count;
   logic [ADDR_W-1:0] top_addr;
   logic [ADDR_W-1:0] peek_addr;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  top_raw;
   logic [WIDTH-1:0]  peek_raw;
   logic              we;
   logic              of_set;
   logic              uf_set;
   logic              peek_zero;
   stack_op_e         op;

   // Capacity is a power of two, so the count MSB alone marks a full stack.
   assign empty       = (count == '0);
   assign full        = count[ADDR_W];
   assign almost_full = (32'(count) >= 32'(AF_LEVEL));

   assign top_addr  = ADDR_W'(count - ONE);
   assign peek_addr = ADDR_W'(count - ONE - {1'b0, peek_idx});
   assign top_data  = empty ? '0 : top_raw;
   assign peek_data = peek_zero ? '0 : peek_raw;

   always_comb begin
      op        = NOP;
      nxt_count = count;
      of_set    = 1'b0;
      uf_set    = 1'b0;
      we        = 1'b0;
      waddr     = count[ADDR_W-1:0];

      if (rollback)
         op = ROLLBACK;
      else if (push && pop && !empty)
         op = REPLACE;
      else if (push)
         op = PUSH;
      else if (pop)
         op = POP;

      case (op)
         PUSH: begin
            if (full) begin
               of_set = 1'b1;
            end else begin
               we        = 1'b1;
               nxt_count = count + ONE;
            end
         end
         POP: begin
            if (empty)
               uf_set = 1'b1;
            else
               nxt_count = count - ONE;
         end
         REPLACE: begin
            we    = 1'b1;
            waddr = top_addr;
         end
         ROLLBACK: nxt_count = mark_ptr;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         mark_ptr   <= '0;
         of         <= 1'b0;
         uf         <= 1'b0;
         peek_valid <= 1'b0;
         peek_zero  <= 1'b1;
      end else begin
         count <= nxt_count;
         // The mark is dragged down with the count so a later rollback never grows the stack.
         if (mark && op != ROLLBACK)
            mark_ptr <= nxt_count;
         else if (nxt_count < mark_ptr)
            mark_ptr <= nxt_count;
         of         <= of_set | (of & ~err_clr);
         uf         <= uf_set | (uf & ~err_clr);
         peek_valid <= peek_req;
         if (peek_req)
            peek_zero <= ({1'b0, peek_idx} >= count);
      end
   end

   lifo_mem #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we      (we),
      .waddr   (waddr),
      .wdata   (d_in),
      .raddr_a (top_addr),
      .rdata_a (top_raw),
      .re_b    (peek_req),
      .raddr_b (peek_addr),
      .rdata_b (peek_raw)
   );

endmodule

`default_nettype wire

// File: doc/lifo_stack_ctrl.md
Name: lifo_stack_ctrl

Overview:
- Parametrised synchronous LIFO for the trax search engine: holds move/tile words for depth-first backtracking.
- Successor to the fixed 22-bit/64-entry stack. Adds:
  - full-capacity use (all 2^ADDR_W entries);
  - simultaneous push+pop (replace top);
  - occupancy count and almost-full flag;
  - registered peek at arbitrary depth;
  - sticky error flags with a clear input;
  - single-level mark/rollback for cheap backtracking.

Parameters:
- WIDTH, 22, data word width in bits.
- ADDR_W, 6, log2 of capacity; capacity = 2^ADDR_W entries.
- AF_LEVEL, 56, almost_full asserts when count >= AF_LEVEL. Legal range 1..2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- push  in  1  write d_in as new top.
- pop  in  1  remove top entry.
- d_in  in  WIDTH  push data.
- mark  in  1  save current count as rollback point.
- rollback  in  1  restore count to saved mark.
- err_clr  in  1  clear of/uf.
- peek_idx  in  ADDR_W  depth from top; 0 = top.
- peek_req  in  1  request a peek read.
- top_data  out  WIDTH  current top entry; 0 when empty.
- peek_data  out  WIDTH  registered peek result.
- peek_valid  out  1  peek_data valid this cycle.
- count  out  ADDR_W+1  number of stored entries, 0..2^ADDR_W.
- empty  out  1  count == 0.
- full  out  1  count == 2^ADDR_W.
- almost_full  out  1  count >= AF_LEVEL.
- of  out  1  sticky overflow.
- uf  out  1  sticky underflow.

Behaviour:
- Reset (sync, highest priority):
  - count = 0, mark_ptr = 0, of = 0, uf = 0, peek_valid = 0, peek_data = 0.
  - Memory contents are not cleared.
- Priority per cycle: reset > rollback > {push, pop} > mark. err_clr acts independently.
- rollback:
  - count <= mark_ptr.
  - push, pop and mark are ignored that cycle; flags unchanged.
- push only:
  - Not full: mem[count] <= d_in; count+1.
  - Full: write dropped, count unchanged, of <= 1.
- pop only:
  - Not empty: count-1.
  - Empty: uf <= 1, count unchanged.
- push and pop together:
  - Not empty: mem[count-1] <= d_in; count unchanged; no flag change. Legal when full.
  - Empty: treated as push only.
- mark: mark_ptr <= count value after this cycle's push/pop.
- Mark tracking: whenever count would drop below mark_ptr, mark_ptr follows the new count. mark_ptr never exceeds count.
- err_clr: clears of/uf. If the same cycle sets a flag, set wins.
- Flag clearing: of/uf are cleared only by reset or err_clr, never by a subsequent pop/push.
- top_data: combinational read of mem[count-1]. Reflects a push on the cycle after the edge.
- Peek:
  - peek_req at edge N: peek_valid = 1 and peek_data = mem[count-1-peek_idx] during cycle N+1, sampled with the pre-edge count.
  - If peek_idx >= count: peek_data = 0 and peek_valid = 1.
  - peek_valid is high for one cycle per request; back-to-back requests are allowed.
- Flags: empty, full, almost_full are combinational from count. There is no wrap-around; count saturates at 0 and 2^ADDR_W.

Decomposition:
- Shared package trax_pkg holds:
  - TRAX_WORD_W = 22, the default WIDTH;
  - STACK_ADDR_W = 6;
  - the stack_op_e enum (NOP, PUSH, POP, REPLACE, ROLLBACK) used by both RTL and bench.
- One natural sub-module: lifo_mem, an inferred 2^ADDR_W x WIDTH RAM with 1 write port, 1 async read (top) and 1 sync read (peek).
- Pointer, mark and flag logic stays in lifo_stack_ctrl.

Test Plan (WIDTH=22, ADDR_W=3, AF_LEVEL=6 unless noted):
- Fill/overflow: push 0x1..0x9 on consecutive cycles.
  - count 0→8; almost_full from count 6; full after 8th push.
  - 9th push sets of = 1, top_data stays 0x8.
  - err_clr → of = 0.
- Drain/underflow: from full, 9 pops.
  - top_data sequence 0x8..0x1, then 0; empty after 8th pop.
  - 9th pop sets uf = 1; count stays 0.
- Replace: push 0xA, 0xB, then push+pop with d_in = 0xC.
  - count stays 2, top_data = 0xC.
  - push+pop while empty with d_in = 0xD → count 1, top 0xD.
- Mark/rollback: push 0x1, 0x2, mark, push 0x3, 0x4, rollback.
  - count = 2, top_data = 0x2.
  - Pop twice, then rollback: count stays 0 (mark followed count).
- Peek: stack holds 0x1, 0x2, 0x3 (top 0x3).
  - peek_idx 0/1/2 on consecutive cycles → peek_data 0x3/0x2/0x1, one cycle later each.
  - peek_idx 5 → 0 with peek_valid = 1.
- Reset mid-operation: full stack with of = 1, then reset together with push.
  - Next cycle count = 0, empty = 1, of = 0, peek_valid = 0; push ignored.
